// File: rtl/load_store_unit.sv
// Load/store unit: turns one datapath load/store into a single memory request,
// holding the pipeline with stall until the extended load data can retire.
module load_store_unit #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [2:0]       funct3,
    input  logic [width-1:0] ALUResult,
    input  logic [width-1:0] WriteData,
    output logic [width-1:0] ReadData,
    output logic             stall,
    output logic             misaligned,
    output logic             mem_req,
    output logic             mem_we,
    output logic [width-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [width-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [width-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e           state_q, state_d;
    logic [width-1:0] addr_q, wdata_q, rdata_q;
    logic [3:0]       be_q;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;

    logic             access, illegal, bad_align, start;
    logic [3:0]       be_d;
    logic [width-1:0] wdata_d, shifted, load_ext;
    logic [15:0]      half_sel;

    assign access  = MemRead | MemWrite;
    assign illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);

    always_comb begin
        bad_align = 1'b0;
        be_d      = 4'b1111;
        wdata_d   = WriteData;
        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ALUResult[1:0];
                wdata_d = {4{WriteData[7:0]}};
            end
            2'b01: begin
                bad_align = ALUResult[0];
                be_d      = ALUResult[1] ? 4'b1100 : 4'b0011;
                wdata_d   = {2{WriteData[15:0]}};
            end
            default: bad_align = |ALUResult[1:0];
        endcase
    end

    assign misaligned = access & (illegal | bad_align);
    assign start      = (state_q == StIdle) & access & ~misaligned;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StReq;
            StReq:   if (mem_ready) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= 4'b0000;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (start) begin
                addr_q  <= {ALUResult[width-1:2], 2'b00};
                wdata_q <= wdata_d;
                be_q    <= be_d;
                we_q    <= MemWrite;
                f3_q    <= funct3;
                off_q   <= ALUResult[1:0];
            end
            if ((state_q == StReq) && mem_ready && !we_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Request outputs are gated so nothing leaks onto the bus outside StReq.
    assign mem_req   = (state_q == StReq);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = mem_req ? addr_q : '0;
    assign mem_be    = mem_req ? be_q : 4'b0000;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign stall     = start | mem_req;

    assign shifted  = rdata_q >> {off_q, 3'b000};
    assign half_sel = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = rdata_q;
        endcase
    end

    assign ReadData = ((state_q == StDone) && !we_q) ? load_ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases with literal expectations plus
// randomized accesses checked every cycle against a transaction-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALUResult, WriteData, ReadData;
    logic        stall, misaligned, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ready;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic        e_mis, e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0]  e_be;
    logic [31:0] req_addr, req_wd, done_rd;
    logic [3:0]  req_be;

    load_store_unit #(.width(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .stall      (stall),
        .misaligned (misaligned),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: access size in bytes from funct3, legality from the encoding table.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int m = (1 << nbytes(f3)) - 1;
        m = m << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
        if (nbytes(f3) == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (nbytes(f3) == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        int nb = nbytes(f3);
        longint unsigned m = (64'd1 << (8 * nb)) - 1;
        longint unsigned v = ({32'd0, word} >> (8 * (a % 4))) & m;
        if (f3 < 4 && v[8*nb-1]) v = v | ~m;
        return v[31:0];
    endfunction

    task automatic set_exp(input logic mis, input logic st, input logic rq, input logic we,
                           input logic [31:0] ad, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] rd);
        e_mis = mis; e_stall = st; e_req = rq; e_we = we;
        e_addr = ad; e_be = be; e_wd = wd; e_rd = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("misaligned", misaligned, e_mis);
            chk("stall", stall, e_stall);
            chk("mem_req", mem_req, e_req);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_be", mem_be, e_be);
            if (!e_req || e_we) chk("mem_wdata", mem_wdata, e_wd);
            chk("ReadData", ReadData, e_rd);
        end
    end

    task automatic go_idle();
        MemRead = 1'b0;
        MemWrite = 1'b0;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdv, input int waits);
        MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; WriteData = wd;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        set_exp(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        for (int i = 0; i <= waits; i++) begin
            mem_ready = (i == waits);
            mem_rdata = (i == waits) ? rdv : $urandom;
            set_exp(0, 1, 1, wr, {a[31:2], 2'b00}, model_be(f3, a), model_wd(f3, wd), 0);
            if (i == 0) begin
                @(negedge clk);
                req_addr = mem_addr; req_be = mem_be; req_wd = mem_wdata;
            end
            step();
        end
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        set_exp(0, 0, 0, 0, 0, 0, 0, wr ? 32'd0 : model_load(f3, a, rdv));
        @(negedge clk);
        done_rd = ReadData;
        step();
        go_idle();
    endtask

    task automatic mis_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a);
        MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = a; WriteData = $urandom;
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        set_exp(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        go_idle();
    endtask

    initial begin
        reset_n = 1'b0;
        MemRead = 0; MemWrite = 0; funct3 = 0; ALUResult = 0; WriteData = 0;
        mem_ready = 0; mem_rdata = 0;
        go_idle();
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_ReadData", ReadData, 0);
        chk("rst_stall", stall, 0);
        #10 reset_n = 1'b1;
        chk_en = 1'b1;
        step();

        // LW 0x104 with memory ready at once
        do_access(1, 0, 3'b010, 32'h104, 0, 32'hDEADBEEF, 0);
        chk("lw_addr", req_addr, 32'h104);
        chk("lw_be", req_be, 4'b1111);
        chk("lw_data", done_rd, 32'hDEADBEEF);
        do_access(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 0);
        chk("lb_data", done_rd, 32'hFFFFFF80);
        do_access(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 1);
        chk("lbu_data", done_rd, 32'h00000080);
        do_access(1, 0, 3'b101, 32'h102, 0, 32'h80FF1234, 0);
        chk("lhu_data", done_rd, 32'h000080FF);
        step();
        do_access(0, 1, 3'b001, 32'h206, 32'h0000ABCD, 0, 0);
        chk("sh_addr", req_addr, 32'h204);
        chk("sh_be", req_be, 4'b1100);
        chk("sh_wdata", req_wd, 32'hABCDABCD);
        // Three wait cycles; model checks stall/addr stability every cycle
        do_access(1, 0, 3'b010, 32'h40, 0, 32'h1234_5678, 3);
        chk("wait_data", done_rd, 32'h1234_5678);
        // Both strobes high is a write
        do_access(1, 1, 3'b000, 32'h11, 32'h5A, 32'hFFFF_FFFF, 0);
        chk("rw_wdata", req_wd, 32'h5A5A5A5A);
        chk("rw_data", done_rd, 32'h0);
        mis_access(1, 0, 3'b010, 32'h102);
        mis_access(1, 0, 3'b011, 32'h100);
        mis_access(0, 1, 3'b001, 32'h207);
        step();

        // Reset in the middle of a request
        MemRead = 1; MemWrite = 0; funct3 = 3'b010; ALUResult = 32'h300;
        mem_ready = 1'b0;
        set_exp(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        set_exp(0, 1, 1, 0, 32'h300, 4'b1111, 0, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async_req_drop", mem_req, 0);
        chk("async_addr_zero", mem_addr, 0);
        chk("async_be_zero", mem_be, 0);
        go_idle();
        step();
        reset_n = 1'b1;
        mem_ready = 1'b1;
        repeat (3) step();
        do_access(1, 0, 3'b001, 32'h302, 0, 32'h8001_0000, 0);
        chk("post_rst_lh", done_rd, 32'hFFFF8001);

        for (int n = 0; n < 80; n++) begin
            logic        rd, wr;
            logic [2:0]  f3;
            logic [31:0] a;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if (!(rd | wr)) begin
                funct3 = f3; ALUResult = a;
                go_idle();
                step();
            end else if (model_mis(f3, a)) begin
                mis_access(rd, wr, f3, a);
            end else begin
                do_access(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3));
            end
        end
        step();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
